// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between mem_access_ctrl, its requesters (core, loader) and the data memory.
// The controller connects through the slave modport; the surrounding system uses master.
interface mem_access_ctrl_if #(
    parameter int ADDRESS_WIDTH = 8
);
    logic                     ld_valid_in;
    logic                     ld_ready_out;
    logic [ADDRESS_WIDTH-1:0] ld_address_in;
    logic [31:0]              ld_data_in;
    logic                     ld_done_in;

    logic                     cpu_wvalid_in;
    logic                     cpu_wready_out;
    logic                     cpu_rvalid_in;
    logic                     cpu_rready_out;
    logic [1:0]               cpu_memMode_in;
    logic                     cpu_unsigned_in;
    logic [ADDRESS_WIDTH-1:0] cpu_address_in;
    logic [31:0]              cpu_data_in;
    logic [31:0]              cpu_rdata_out;
    logic                     cpu_rdata_valid_out;
    logic                     cpu_stall_out;

    logic                     mem_write_out;
    logic [1:0]               mem_memMode_out;
    logic [ADDRESS_WIDTH-1:0] mem_write_address_out;
    logic [31:0]              mem_write_data_out;
    logic [ADDRESS_WIDTH-1:0] mem_read_address_1_out;
    logic [31:0]              mem_read_data_1_in;

    modport slave (
        input  ld_valid_in, ld_address_in, ld_data_in, ld_done_in,
        output ld_ready_out,
        input  cpu_wvalid_in, cpu_rvalid_in, cpu_memMode_in, cpu_unsigned_in,
        input  cpu_address_in, cpu_data_in,
        output cpu_wready_out, cpu_rready_out, cpu_rdata_out, cpu_rdata_valid_out,
        output cpu_stall_out,
        output mem_write_out, mem_memMode_out, mem_write_address_out, mem_write_data_out,
        output mem_read_address_1_out,
        input  mem_read_data_1_in
    );

    modport master (
        output ld_valid_in, ld_address_in, ld_data_in, ld_done_in,
        input  ld_ready_out,
        output cpu_wvalid_in, cpu_rvalid_in, cpu_memMode_in, cpu_unsigned_in,
        output cpu_address_in, cpu_data_in,
        input  cpu_wready_out, cpu_rready_out, cpu_rdata_out, cpu_rdata_valid_out,
        input  cpu_stall_out,
        input  mem_write_out, mem_memMode_out, mem_write_address_out, mem_write_data_out,
        input  mem_read_address_1_out,
        output mem_read_data_1_in
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: boots memory from the loader while the core is stalled,
// round-robins the write port between core and loader, and formats core loads.
module mem_access_ctrl #(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic             clock_in,
    input  logic             reset_n_in,
    mem_access_ctrl_if.slave bus
);
    localparam int AW = ADDRESS_WIDTH;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic GRANT_LD  = 1'b0;
    localparam logic GRANT_CPU = 1'b1;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            last_grant_r;

    logic            ld_ready_s;
    logic            cpu_wready_s;
    logic            cpu_rready_s;
    logic            stall_s;
    logic            hazard_s;
    logic            ld_acc_s;
    logic            cpu_wacc_s;
    logic            load_acc_s;

    logic            mem_write_r;
    logic [1:0]      mem_mode_r;
    logic [AW-1:0]   mem_waddr_r;
    logic [31:0]     mem_wdata_r;

    logic            ld1_valid_r;
    logic [1:0]      ld1_off_r;
    logic [1:0]      ld1_mode_r;
    logic            ld1_uns_r;
    logic            rdata_valid_r;
    logic [31:0]     rdata_r;

    // Mode 01 has no meaning to the memory, so it is issued as a plain word access.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        logic [1:0] res;
        case (mode)
            2'b10:   res = 2'b10;
            2'b11:   res = 2'b11;
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] format_load(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] mode, input logic uns);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        logic [31:0] res;
        half_v = off[1] ? word[31:16] : word[15:0];
        case (off)
            2'b00:   byte_v = word[7:0];
            2'b01:   byte_v = word[15:8];
            2'b10:   byte_v = word[23:16];
            2'b11:   byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        case (mode)
            2'b10:   res = uns ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
            2'b11:   res = uns ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
            default: res = word;
        endcase
        return res;
    endfunction

    // A load to the word with a write still pending would read the old contents.
    assign hazard_s   = mem_write_r && (mem_waddr_r[AW-1:2] == bus.cpu_address_in[AW-1:2]);
    assign ld_acc_s   = bus.ld_valid_in & ld_ready_s;
    assign cpu_wacc_s = bus.cpu_wvalid_in & cpu_wready_s;
    assign load_acc_s = bus.cpu_rvalid_in & cpu_rready_s;

    // FSM state register
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; RUN is only left through reset
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: begin
                if (bus.ld_done_in) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_BOOT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_BOOT;
        endcase
    end

    // FSM outputs: handshake readies and core stall
    always_comb begin
        ld_ready_s   = 1'b0;
        cpu_wready_s = 1'b0;
        cpu_rready_s = 1'b0;
        stall_s      = 1'b1;
        case (state_r)
            ST_BOOT: begin
                ld_ready_s = 1'b1;
                stall_s    = 1'b1;
            end
            ST_RUN: begin
                stall_s      = 1'b0;
                ld_ready_s   = bus.ld_valid_in &
                               (~bus.cpu_wvalid_in | (last_grant_r == GRANT_CPU));
                cpu_wready_s = bus.cpu_wvalid_in &
                               (~bus.ld_valid_in | (last_grant_r == GRANT_LD));
                cpu_rready_s = ~hazard_s;
            end
            default: begin
                stall_s = 1'b1;
            end
        endcase
    end

    // Round-robin history, moved only by an accepted write
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            last_grant_r <= GRANT_LD;
        end else if (ld_acc_s) begin
            last_grant_r <= GRANT_LD;
        end else if (cpu_wacc_s) begin
            last_grant_r <= GRANT_CPU;
        end
    end

    // Memory write-port registers
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            mem_write_r <= 1'b0;
            mem_mode_r  <= 2'b00;
            mem_waddr_r <= '0;
            mem_wdata_r <= 32'h0000_0000;
        end else if (ld_acc_s) begin
            mem_write_r <= 1'b1;
            mem_mode_r  <= 2'b00;
            mem_waddr_r <= bus.ld_address_in & {{(AW-2){1'b1}}, 2'b00};
            mem_wdata_r <= bus.ld_data_in;
        end else if (cpu_wacc_s) begin
            mem_write_r <= 1'b1;
            mem_mode_r  <= norm_mode(bus.cpu_memMode_in);
            mem_waddr_r <= bus.cpu_address_in;
            mem_wdata_r <= bus.cpu_data_in;
        end else begin
            mem_write_r <= 1'b0;
        end
    end

    // Load stage 1: remember how to format the word the memory returns next cycle
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            ld1_valid_r <= 1'b0;
            ld1_off_r   <= 2'b00;
            ld1_mode_r  <= 2'b00;
            ld1_uns_r   <= 1'b0;
        end else begin
            ld1_valid_r <= load_acc_s;
            if (load_acc_s) begin
                ld1_off_r  <= bus.cpu_address_in[1:0];
                ld1_mode_r <= bus.cpu_memMode_in;
                ld1_uns_r  <= bus.cpu_unsigned_in;
            end
        end
    end

    // Load stage 2: register the aligned and extended result
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            rdata_valid_r <= 1'b0;
            rdata_r       <= 32'h0000_0000;
        end else begin
            rdata_valid_r <= ld1_valid_r;
            if (ld1_valid_r) begin
                rdata_r <= format_load(bus.mem_read_data_1_in, ld1_off_r, ld1_mode_r, ld1_uns_r);
            end
        end
    end

    assign bus.ld_ready_out           = ld_ready_s;
    assign bus.cpu_wready_out         = cpu_wready_s;
    assign bus.cpu_rready_out         = cpu_rready_s;
    assign bus.cpu_stall_out          = stall_s;
    assign bus.cpu_rdata_out          = rdata_r;
    assign bus.cpu_rdata_valid_out    = rdata_valid_r;
    assign bus.mem_write_out          = mem_write_r;
    assign bus.mem_memMode_out        = mem_mode_r;
    assign bus.mem_write_address_out  = mem_waddr_r;
    assign bus.mem_write_data_out     = mem_wdata_r;
    assign bus.mem_read_address_1_out = bus.cpu_address_in;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Access controller between the MIPS core and the tri-port data memory. Boots the memory from a word-wide loader while the core is stalled, then round-robin arbitrates the single write port between core stores and loader (debug) writes. Also drives read port 1 for core loads, with a two-cycle load pipeline that aligns and sign/zero-extends byte and half results. Read port 0 (instruction fetch) is not touched.

## Interface
- ADDRESS_WIDTH, 8: byte-address width of the memory.
- clock_in  in  1  single clock; the memory's read and write clocks use the same clock.
- reset_n_in  in  1  synchronous, active-low reset.
- ld_valid_in / ld_ready_out  in/out  1  loader write handshake.
- ld_address_in  in  ADDRESS_WIDTH  loader byte address; bits [1:0] are forced to 0.
- ld_data_in  in  32  loader write word.
- ld_done_in  in  1  loader finished; sampled only in BOOT.
- cpu_wvalid_in / cpu_wready_out  in/out  1  core store handshake.
- cpu_rvalid_in / cpu_rready_out  in/out  1  core load handshake.
- cpu_memMode_in  in  2  access size: 00 word, 10 half, 11 byte, 01 treated as word.
- cpu_unsigned_in  in  1  load zero-extends when 1.
- cpu_address_in  in  ADDRESS_WIDTH  core byte address, shared by stores and loads.
- cpu_data_in  in  32  store data, right-aligned.
- cpu_rdata_out  out  32  formatted load result.
- cpu_rdata_valid_out  out  1  one-cycle strobe marking cpu_rdata_out valid.
- cpu_stall_out  out  1  high while in BOOT.
- mem_write_out, mem_memMode_out[2], mem_write_address_out[ADDRESS_WIDTH], mem_write_data_out[32]  out  registered drive of the memory write port.
- mem_read_address_1_out  out  ADDRESS_WIDTH  combinational copy of cpu_address_in.
- mem_read_data_1_in  in  32  memory read port 1 data.

## Operation
- **States:**
  - BOOT (reset state):
    - ld_ready_out=1; cpu_wready_out=0, cpu_rready_out=0; cpu_stall_out=1.
    - A cycle with ld_done_in=1 moves the FSM to RUN at the next edge.
    - A loader write in that same cycle is still accepted.
  - RUN:
    - cpu_stall_out=0; ld_done_in is ignored.
    - The FSM leaves RUN only on reset.
- **Write arbitration (RUN):**
  - With one requester valid, that requester gets ready.
  - With both valid, grant goes to the requester not granted last. The last_grant flag resets to "loader", so the core wins the first conflict.
  - last_grant updates only on an accepted transfer.
  - Ready signals are combinational from state, valids and last_grant. At most one ready is high per cycle.
- **Accepted write:**
  - Registers into mem_write_out=1, mem_memMode_out, mem_write_address_out and mem_write_data_out.
  - Loader writes force mem_memMode_out=00 and address bits [1:0] to 00.
  - With no accept, mem_write_out=0 next cycle; the other mem_* registers hold their values.
- **Load issue:** a load transfers when cpu_rvalid_in & cpu_rready_out. cpu_rready_out is 1 in RUN except in this hazard case:
  - mem_write_out=1, and
  - mem_write_address_out[AW-1:2] equals cpu_address_in[AW-1:2].

  This avoids returning stale data for the pending write.
- **Load format:** address[1:0], mode and unsigned are captured at issue.
  - Word: data unchanged.
  - Half: lane [31:16] if addr[1] else [15:0].
  - Byte: lane addr[1:0]×8.
  - Extension: sign-extend unless unsigned.
- **Concurrency:**
  - A store and a load may transfer in the same cycle; they share cpu_address_in.
  - Back-to-back loads are accepted every cycle.

## Timing
- **Reset values:**
  - State = BOOT; last_grant = loader.
  - All mem_* outputs 0; cpu_rdata_out = 0; cpu_rdata_valid_out = 0; cpu_stall_out = 1.
  - The load pipeline is flushed; an in-flight load produces no strobe.
- **Write path:** write accepted in cycle N → mem_write_out high in cycle N+1 → memory commits at the end of N+1.
- **Load path:**
  - Load accepted in cycle N → memory samples the address at the end of N.
  - Data is present in N+1; the formatted result is registered at the end of N+1.
  - cpu_rdata_valid_out=1 for exactly cycle N+2.
- **Throughput:** one write and one load per cycle.
- **Stall exit:** ld_done_in high in cycle N → cpu_stall_out=0 in N+1.

## Test plan
- **Boot:** after reset, loader writes 0x11223344 @0x00 and 0xAABBCCDD @0x04, with ld_done_in asserted alongside the second write → both words are written in word mode; cpu_stall_out falls one cycle after done; core loads return 0x11223344 and 0xAABBCCDD with cpu_rdata_valid_out 2 cycles after issue.
- **Conflict:** in RUN, core and loader valid together for 4 cycles, to distinct addresses → grants alternate core, loader, core, loader; exactly one ready per cycle.
- **Sub-word load:** memory word 0x80FF7F01 @0x10 → byte @0x11 signed = 0x0000007F; byte @0x13 signed = 0xFFFFFF80; byte @0x12 unsigned = 0x000000FF; half @0x12 signed = 0xFFFF80FF; half @0x10 unsigned = 0x00007F01.
- **Sub-word store:** byte store 0x5A @0x11 then half store 0xBEEF @0x12 over 0x00000000 → word load @0x10 returns 0xBEEF5A00.
- **Hazard:** store to 0x20 accepted in cycle N, load 0x21 presented in N+1 → cpu_rready_out=0 in N+1 and 1 in N+2; the load returns the new byte.
- **Reset mid-operation:** reset_n_in low the cycle after a load issue → no cpu_rdata_valid_out strobe; state = BOOT, cpu_stall_out=1, mem_write_out=0.
